// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM state
// encodings, parity codes, frame width and parity helpers.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // True when the parity code asks for a parity bit (code 3 means none).
    function automatic logic par_enabled(input logic [1:0] code);
        return (code == PAR_EVEN) || (code == PAR_ODD);
    endfunction

    // Parity bit for a data byte under the given parity code.
    function automatic logic par_bit_of(input logic [DATA_BITS-1:0] data,
                                        input logic [1:0]           code);
        logic result;
        case (code)
            PAR_EVEN: result = ^data;
            PAR_ODD:  result = ~^data;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Sample-tick generator: a down-counter that pulses tick whenever it sits
// at zero and reloads from baud_div. load_i restarts the period so a frame
// begins on an exact tick boundary.
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] baud_div,
    output logic        tick
);

    logic [15:0] div;

    // Count down to zero, reloading on zero or on an explicit restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= 16'd0;
        end else if (load_i || (div == 16'd0)) begin
            div <= baud_div;
        end else begin
            div <= div - 16'd1;
        end
    end

    assign tick = (div == 16'd0);

endmodule

// File: rtl/uart_tx.sv
// 16x-oversampled UART transmitter: 8 data bits LSB first, optional
// even/odd parity, one or two stop bits, and an idle-state line break.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [7:0] OVERSAMPLE = 8'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baud_div,
    input  logic [1:0]  parity,
    input  logic        stop2,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        break_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [7:0] OS_MAX  = OVERSAMPLE - 8'd1;
    localparam logic [2:0] BIT_MAX = 3'(DATA_BITS - 1);

    state_t               state;
    logic [DATA_BITS-1:0] sh;
    logic                 par_bit;
    logic [1:0]           par_cfg;
    logic                 stop2_cfg;
    logic [7:0]           os;
    logic [2:0]           bitn;
    logic                 tick;
    logic                 accept;
    logic                 advance;

    // ready_o follows the state register and break_i directly so that a
    // break request blocks acceptance in the very cycle it is raised.
    assign ready_o = (state == S_IDLE) && !break_i;
    assign accept  = valid_i && ready_o;
    assign advance = tick && (os == 8'd0);

    uart_baud_gen u_baud (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .baud_div (baud_div),
        .tick     (tick)
    );

    // Frame sequencer: latches a byte on acceptance and walks start, data,
    // parity and stop bits, changing tx_o only on bit-advance edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            sh        <= '0;
            par_bit   <= 1'b0;
            par_cfg   <= PAR_NONE;
            stop2_cfg <= 1'b0;
            os        <= 8'd0;
            bitn      <= 3'd0;
        end else begin
            done_o <= 1'b0;

            if (state != S_IDLE && tick) begin
                os <= (os == 8'd0) ? OS_MAX : os - 8'd1;
            end

            case (state)
                S_IDLE: begin
                    tx_o <= ~break_i;
                    if (accept) begin
                        sh        <= data_i;
                        par_cfg   <= parity;
                        stop2_cfg <= stop2;
                        par_bit   <= par_bit_of(data_i, parity);
                        os        <= OS_MAX;
                        bitn      <= 3'd0;
                        state     <= S_START;
                        tx_o      <= 1'b0;
                        busy_o    <= 1'b1;
                    end
                end
                S_START: begin
                    if (advance) begin
                        state <= S_DATA;
                        bitn  <= 3'd0;
                        tx_o  <= sh[0];
                    end
                end
                S_DATA: begin
                    if (advance) begin
                        if (bitn == BIT_MAX) begin
                            bitn <= 3'd0;
                            if (par_enabled(par_cfg)) begin
                                state <= S_PAR;
                                tx_o  <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            bitn <= bitn + 3'd1;
                            sh   <= sh >> 1;
                            tx_o <= sh[1];
                        end
                    end
                end
                S_PAR: begin
                    if (advance) begin
                        state <= S_STOP;
                        bitn  <= 3'd0;
                        tx_o  <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (advance) begin
                        if (stop2_cfg && (bitn == 3'd0)) begin
                            bitn <= 3'd1;
                        end else begin
                            state  <= S_IDLE;
                            bitn   <= 3'd0;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            tx_o   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected serial bit sequences are queued when
// a byte is handed over and checked clock by clock as the line toggles.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  parity;
    logic        stop2;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic        break_i;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q[$];

    uart_tx #(.OVERSAMPLE(8'd16)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .parity   (parity),
        .stop2    (stop2),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .break_i  (break_i),
        .tx_o     (tx_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a byte, wait (bounded) for ready, then queue its expected bits.
    task automatic accept(input logic [7:0] d);
        int w;
        w       = 0;
        data_i  = d;
        valid_i = 1'b1;
        while (ready_o !== 1'b1 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (ready_o !== 1'b1) begin
            chk("accept_ready", ready_o, 1);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (parity == 2'd1) exp_q.push_back(^d);
        else if (parity == 2'd2) exp_q.push_back(~^d);
        exp_q.push_back(1'b1);
        if (stop2) exp_q.push_back(1'b1);
    endtask

    // Check every clock of every queued bit, then the end-of-frame cycle.
    task automatic run_frame(input string name, input bit keep, input logic [7:0] nxt,
                             input bit toggle, input bit brk);
        int   n;
        int   b;
        logic e;
        logic otx, obusy, ordy;
        bit   btx, bb, br;
        n = 16 * (int'(baud_div) + 1);
        b = 0;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            btx = 0; bb = 0; br = 0;
            otx = 1'bx; obusy = 1'bx; ordy = 1'bx;
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                if (b == 0 && k == 0) begin
                    if (keep) data_i = nxt;
                    else valid_i = 1'b0;
                end
                if (toggle && b == 3 && k == 0) begin
                    parity = parity ^ 2'd3;
                    stop2  = ~stop2;
                end
                if (brk && b == 2 && k == 0) break_i = 1'b1;
                if (!btx) begin otx = tx_o;     if (tx_o !== e)       btx = 1; end
                if (!bb)  begin obusy = busy_o; if (busy_o !== 1'b1)  bb = 1;  end
                if (!br)  begin ordy = ready_o; if (ready_o !== 1'b0) br = 1;  end
            end
            chk($sformatf("%s bit%0d tx", name, b), otx, e);
            chk($sformatf("%s bit%0d busy", name, b), obusy, 1);
            chk($sformatf("%s bit%0d ready", name, b), ordy, 0);
            b++;
        end
        @(negedge clk);
        chk({name, " done"}, done_o, 1);
        chk({name, " busy_end"}, busy_o, 0);
        chk({name, " tx_end"}, tx_o, 1);
        chk({name, " ready_end"}, ready_o, brk ? 0 : 1);
    endtask

    initial begin
        logic [7:0] bytes [3];
        rst = 1'b1; baud_div = 16'd0; parity = 2'd0; stop2 = 1'b0;
        data_i = 8'h00; valid_i = 1'b0; break_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx", tx_o, 1);
        chk("reset ready", ready_o, 1);
        chk("reset busy", busy_o, 0);
        chk("reset done", done_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 10-bit frame at one tick per clock.
        accept(8'h55);
        run_frame("f55", 0, 8'h00, 0, 0);

        // Parity variants on 0x07.
        parity = 2'd1; accept(8'h07); run_frame("even07", 0, 8'h00, 0, 0);
        parity = 2'd2; accept(8'h07); run_frame("odd07", 0, 8'h00, 0, 0);
        parity = 2'd3; accept(8'h07); run_frame("par3_07", 0, 8'h00, 0, 0);

        // Two stop bits, odd parity, slower ticks, config toggled mid-frame.
        baud_div = 16'd3; parity = 2'd2; stop2 = 1'b1;
        accept(8'hA3);
        run_frame("a3_s2", 0, 8'h00, 1, 0);

        // Back-to-back with valid held high.
        baud_div = 16'd0; parity = 2'd0; stop2 = 1'b0;
        accept(8'h12);
        run_frame("b2b_12", 1, 8'h34, 0, 0);
        accept(8'h34);
        run_frame("b2b_34", 0, 8'h00, 0, 0);

        // Reset during data bit 3 aborts the frame.
        accept(8'h00);
        exp_q.delete();
        @(negedge clk);
        valid_i = 1'b0;
        repeat (69) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst tx", tx_o, 1);
        chk("midrst ready", ready_o, 1);
        chk("midrst busy", busy_o, 0);
        rst = 1'b0;
        accept(8'hE7);
        run_frame("after_rst", 0, 8'h00, 0, 0);

        // Break raised mid-frame only acts once the frame is over.
        accept(8'h3C);
        run_frame("brk", 0, 8'h00, 0, 1);
        valid_i = 1'b1;
        data_i  = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("brk hold%0d tx", i), tx_o, 0);
            chk($sformatf("brk hold%0d ready", i), ready_o, 0);
            chk($sformatf("brk hold%0d busy", i), busy_o, 0);
        end
        valid_i = 1'b0;
        break_i = 1'b0;
        @(negedge clk);
        chk("brk release tx", tx_o, 1);
        chk("brk release ready", ready_o, 1);

        // Sweep of parity / stop-bit combinations with mixed bytes.
        baud_div = 16'd2;
        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < 2; s++) begin
                bytes[0] = 8'h00;
                bytes[1] = 8'hFF;
                bytes[2] = 8'($urandom_range(0, 255));
                for (int j = 0; j < 3; j++) begin
                    parity = 2'(p);
                    stop2  = s[0];
                    accept(bytes[j]);
                    run_frame($sformatf("sw p%0d s%0d b%02h", p, s, bytes[j]), 0, 8'h00, 0, 0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
